// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared FSM state type and constants for the SD SPI byte engine.
package sd_spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      INIT = 2'd3
   } state_t;

   localparam int unsigned INIT_CLOCKS = 80;
   localparam int unsigned BITS        = 8;

endpackage

// File: rtl/sd_spi_clkdiv.sv
// sd_spi_clkdiv: SD_CK half-period counter. Counts while run is high and
// raises tc on the clock where the count equals the selected divider.
module sd_spi_clkdiv #(
   parameter int unsigned DIV_SLOW = 63,
   parameter int unsigned DIV_FAST = 1,
   parameter int unsigned CNT_W    = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic sel_fast,
   output logic tc
);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] div_s;

   // Select the active divider and flag the terminal count.
   always_comb begin
      div_s = '0;
      if (sel_fast) begin
         div_s = CNT_W'(DIV_FAST);
      end else begin
         div_s = CNT_W'(DIV_SLOW);
      end
      tc = run && (cnt_r == div_s);
   end

   // Half-period counter: held at zero when idle, wraps on terminal count.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (!run || tc) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sd_spi_master.sv
// sd_spi_master: SPI mode-0 byte engine for the PCXT SD port.
// Optional build macro SD_SPI_INIT_CLOCKS_EN adds an INIT phase after reset
// that issues 80 slow SD_CK cycles with SD_nCS and SD_DI held high.
module sd_spi_master
   import sd_spi_pkg::*;
#(
   parameter int unsigned DIV_SLOW = 63,
   parameter int unsigned DIV_FAST = 1,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk_chipset,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       fast,
   input  logic       cs_write,
   input  logic       cs_value,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       SD_nCS,
   output logic       SD_CK,
   output logic       SD_DI,
   input  logic       SD_DO
);

   state_t     state_r, state_nxt;
   logic [7:0] shift_r, shift_nxt;
   logic [2:0] bit_r,   bit_nxt;
   logic       fast_r,  fast_nxt;
   logic       ck_r,    ck_nxt;
   logic       di_r,    di_nxt;
   logic       ncs_r,   ncs_nxt;
   logic       busy_r,  busy_nxt;
   logic       done_r,  done_nxt;
   logic [7:0] rx_r,    rx_nxt;
   logic       run_s;
   logic       tc_s;
`ifdef SD_SPI_INIT_CLOCKS_EN
   logic [6:0] init_r,  init_nxt;
`endif

   assign run_s = (state_r != IDLE);

   sd_spi_clkdiv #(
      .DIV_SLOW (DIV_SLOW),
      .DIV_FAST (DIV_FAST),
      .CNT_W    (CNT_W)
   ) u_clkdiv (
      .clk      (clk_chipset),
      .reset    (reset),
      .run      (run_s),
      .sel_fast (fast_r),
      .tc       (tc_s)
   );

   // State register.
   always_ff @(posedge clk_chipset) begin
      if (reset) begin
`ifdef SD_SPI_INIT_CLOCKS_EN
         state_r <= INIT;
`else
         state_r <= IDLE;
`endif
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state and next-output logic for the byte engine.
   always_comb begin
      state_nxt = state_r;
      shift_nxt = shift_r;
      bit_nxt   = bit_r;
      fast_nxt  = fast_r;
      ck_nxt    = ck_r;
      di_nxt    = di_r;
      ncs_nxt   = ncs_r;
      busy_nxt  = busy_r;
      done_nxt  = 1'b0;
      rx_nxt    = rx_r;
`ifdef SD_SPI_INIT_CLOCKS_EN
      init_nxt  = init_r;
`endif
      case (state_r)
         IDLE: begin
            busy_nxt = 1'b0;
            if (start) begin
               shift_nxt = tx_data;
               fast_nxt  = fast;
               busy_nxt  = 1'b1;
               di_nxt    = tx_data[7];
               bit_nxt   = 3'(BITS - 1);
               state_nxt = LOW;
            end else begin
               state_nxt = IDLE;
            end
            if (cs_write) begin
               ncs_nxt = cs_value;
            end else begin
               ncs_nxt = ncs_r;
            end
         end
         LOW: begin
            if (tc_s) begin
               ck_nxt    = 1'b1;
               shift_nxt = {shift_r[6:0], SD_DO};
               state_nxt = HIGH;
            end else begin
               state_nxt = LOW;
            end
         end
         HIGH: begin
            if (tc_s) begin
               ck_nxt = 1'b0;
               if (bit_r != 3'd0) begin
                  bit_nxt   = bit_r - 3'd1;
                  di_nxt    = shift_r[7];
                  state_nxt = LOW;
               end else begin
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  rx_nxt    = shift_r;
                  di_nxt    = 1'b1;
               end
            end else begin
               state_nxt = HIGH;
            end
         end
`ifdef SD_SPI_INIT_CLOCKS_EN
         INIT: begin
            busy_nxt = 1'b1;
            ncs_nxt  = 1'b1;
            di_nxt   = 1'b1;
            if (tc_s) begin
               if (!ck_r) begin
                  ck_nxt = 1'b1;
               end else begin
                  ck_nxt = 1'b0;
                  if (init_r == 7'(INIT_CLOCKS - 1)) begin
                     init_nxt  = 7'd0;
                     busy_nxt  = 1'b0;
                     state_nxt = IDLE;
                  end else begin
                     init_nxt = init_r + 7'd1;
                  end
               end
            end else begin
               state_nxt = INIT;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            ck_nxt    = 1'b0;
            di_nxt    = 1'b1;
         end
      endcase
   end

   // Datapath and registered pin/status outputs.
   always_ff @(posedge clk_chipset) begin
      if (reset) begin
         shift_r <= 8'h00;
         bit_r   <= 3'd0;
         fast_r  <= 1'b0;
         ck_r    <= 1'b0;
         di_r    <= 1'b1;
         ncs_r   <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         rx_r    <= 8'h00;
      end else begin
         shift_r <= shift_nxt;
         bit_r   <= bit_nxt;
         fast_r  <= fast_nxt;
         ck_r    <= ck_nxt;
         di_r    <= di_nxt;
         ncs_r   <= ncs_nxt;
         busy_r  <= busy_nxt;
         done_r  <= done_nxt;
         rx_r    <= rx_nxt;
      end
   end

`ifdef SD_SPI_INIT_CLOCKS_EN
   // Counter of completed SD_CK cycles during the power-up clock train.
   always_ff @(posedge clk_chipset) begin
      if (reset) begin
         init_r <= 7'd0;
      end else begin
         init_r <= init_nxt;
      end
   end
`endif

   assign busy    = busy_r;
   assign done    = done_r;
   assign rx_data = rx_r;
   assign SD_nCS  = ncs_r;
   assign SD_CK   = ck_r;
   assign SD_DI   = di_r;

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: directed self-checking bench for sd_spi_master
// (default DIV_SLOW=63, DIV_FAST=1).
module tb_sd_spi_master;

   logic       clk_chipset = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] tx_data;
   logic       fast;
   logic       cs_write;
   logic       cs_value;
   logic       busy;
   logic       done;
   logic [7:0] rx_data;
   logic       SD_nCS;
   logic       SD_CK;
   logic       SD_DI;
   logic       SD_DO;
   logic       loop_en;
   logic       do_val;

   int n_vec = 0;
   int n_err = 0;

   // Transfer measurements filled in by run_xfer.
   int         lat, rises, n_done, hi_min, hi_max, lo_min, lo_max;
   logic [7:0] di_bits;
   logic       ncs_first, ncs_hi_seen;

   assign SD_DO = loop_en ? SD_DI : do_val;

   always #5 clk_chipset = ~clk_chipset;

   sd_spi_master dut (
      .clk_chipset (clk_chipset),
      .reset       (reset),
      .start       (start),
      .tx_data     (tx_data),
      .fast        (fast),
      .cs_write    (cs_write),
      .cs_value    (cs_value),
      .busy        (busy),
      .done        (done),
      .rx_data     (rx_data),
      .SD_nCS      (SD_nCS),
      .SD_CK       (SD_CK),
      .SD_DI       (SD_DI),
      .SD_DO       (SD_DO)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_chipset);
      #1;
   endtask

   // Issue one start (optionally with a same-cycle cs_write of 0), then watch
   // SD_CK/SD_DI/done for `window` cycles. At cycle mid_tick optionally pulse
   // a second start and/or a cs_write of 1.
   task automatic run_xfer(input logic [7:0] tx, input logic f, input int window,
                           input int mid_tick, input logic mid_start,
                           input logic mid_cs, input logic cs0);
      logic prev_ck;
      logic fell;
      int   hrun, lrun;
      lat = 0; rises = 0; n_done = 0;
      hi_min = 1000000; hi_max = 0; lo_min = 1000000; lo_max = 0;
      di_bits = 8'h00; ncs_first = 1'b1; ncs_hi_seen = 1'b0;
      hrun = 0; lrun = 0; fell = 1'b0;
      tx_data  = tx;
      fast     = f;
      start    = 1'b1;
      cs_write = cs0;
      cs_value = 1'b0;
      prev_ck  = SD_CK;
      for (int t = 1; t <= window; t++) begin
         tick();
         start    = 1'b0;
         cs_write = 1'b0;
         fast     = ~f;
         if (t == mid_tick) begin
            start    = mid_start;
            cs_write = mid_cs;
            cs_value = 1'b1;
         end
         if (done) begin
            n_done++;
            if (lat == 0) lat = t;
         end
         if (busy && SD_nCS) ncs_hi_seen = 1'b1;
         if (SD_CK && !prev_ck) begin
            if (rises < 8) di_bits = {di_bits[6:0], SD_DI};
            if (rises == 0) ncs_first = SD_nCS;
            rises++;
            if (fell) begin
               if (lrun < lo_min) lo_min = lrun;
               if (lrun > lo_max) lo_max = lrun;
            end
            hrun = 1;
         end else if (!SD_CK && prev_ck) begin
            if (hrun < hi_min) hi_min = hrun;
            if (hrun > hi_max) hi_max = hrun;
            fell = 1'b1;
            lrun = 1;
         end else if (SD_CK) begin
            hrun++;
         end else begin
            lrun++;
         end
         prev_ck = SD_CK;
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      tx_data  = 8'h00;
      fast     = 1'b0;
      cs_write = 1'b0;
      cs_value = 1'b1;
      loop_en  = 1'b1;
      do_val   = 1'b0;
      tick(); tick(); tick();

      // Reset state
      chk("rst_ncs",  32'(SD_nCS),  32'd1);
      chk("rst_ck",   32'(SD_CK),   32'd0);
      chk("rst_di",   32'(SD_DI),   32'd1);
      chk("rst_busy", 32'(busy),    32'd0);
      chk("rst_done", 32'(done),    32'd0);
      chk("rst_rx",   32'(rx_data), 32'h00);
      reset = 1'b0;

`ifdef SD_SPI_INIT_CLOCKS_EN
      begin
         int   irises, ifalls, fall80, busy_fall, idone;
         logic prev, bad_ncs, bad_di, was_busy;
         irises = 0; ifalls = 0; fall80 = 0; busy_fall = 0; idone = 0;
         bad_ncs = 1'b0; bad_di = 1'b0; was_busy = 1'b0; prev = SD_CK;
         for (int t = 1; t <= 10500; t++) begin
            tick();
            start = (t == 100);
            tx_data = 8'h81;
            if (done) idone++;
            if (busy) was_busy = 1'b1;
            if (was_busy && !busy && busy_fall == 0) busy_fall = t;
            if (busy && !SD_nCS) bad_ncs = 1'b1;
            if (busy && !SD_DI) bad_di = 1'b1;
            if (SD_CK && !prev) irises++;
            if (!SD_CK && prev) begin
               ifalls++;
               if (ifalls == 80) fall80 = t;
            end
            prev = SD_CK;
         end
         start = 1'b0;
         chk("init_rises",    32'(irises),    32'd80);
         chk("init_busyfall", 32'(busy_fall), 32'(fall80));
         chk("init_ncs",      32'(bad_ncs),   32'd0);
         chk("init_di",       32'(bad_di),    32'd0);
         chk("init_done",     32'(idone),     32'd0);
         chk("init_busy_end", 32'(busy),      32'd0);
      end
`endif

      // Loopback, fast, 0xA5
      loop_en = 1'b1;
      run_xfer(8'hA5, 1'b1, 45, -1, 1'b0, 1'b0, 1'b0);
      chk("a5_lat",    32'(lat),     32'd33);
      chk("a5_rx",     32'(rx_data), 32'hA5);
      chk("a5_rises",  32'(rises),   32'd8);
      chk("a5_di",     32'(di_bits), 32'hA5);
      chk("a5_hi_min", 32'(hi_min),  32'd2);
      chk("a5_hi_max", 32'(hi_max),  32'd2);
      chk("a5_lo_min", 32'(lo_min),  32'd2);
      chk("a5_lo_max", 32'(lo_max),  32'd2);
      chk("a5_ndone",  32'(n_done),  32'd1);
      chk("a5_busy",   32'(busy),    32'd0);
      chk("a5_di_idle",32'(SD_DI),   32'd1);

      // SD_DO tied low, slow, 0xFF
      loop_en = 1'b0;
      do_val  = 1'b0;
      run_xfer(8'hFF, 1'b0, 1060, -1, 1'b0, 1'b0, 1'b0);
      chk("ff_lat",    32'(lat),     32'd1025);
      chk("ff_rx",     32'(rx_data), 32'h00);
      chk("ff_rises",  32'(rises),   32'd8);
      chk("ff_di",     32'(di_bits), 32'hFF);
      chk("ff_hi",     32'(hi_max),  32'd64);
      chk("ff_lo",     32'(lo_min),  32'd64);

      // cs_write(0) with start; cs_write(1) mid-transfer is ignored
      loop_en = 1'b1;
      run_xfer(8'h3C, 1'b1, 45, 10, 1'b0, 1'b1, 1'b1);
      chk("cs_first",  32'(ncs_first),   32'd0);
      chk("cs_mid",    32'(ncs_hi_seen), 32'd0);
      chk("cs_after",  32'(SD_nCS),      32'd0);
      chk("cs_rx",     32'(rx_data),     32'h3C);
      chk("cs_lat",    32'(lat),         32'd33);
      cs_write = 1'b1;
      cs_value = 1'b1;
      tick();
      cs_write = 1'b0;
      chk("cs_idle_wr", 32'(SD_nCS), 32'd1);

      // Second start while busy is dropped
      run_xfer(8'h5A, 1'b1, 80, 6, 1'b1, 1'b0, 1'b0);
      chk("dbl_ndone", 32'(n_done),  32'd1);
      chk("dbl_rises", 32'(rises),   32'd8);
      chk("dbl_lat",   32'(lat),     32'd33);
      chk("dbl_rx",    32'(rx_data), 32'h5A);

      // Reset during bit 4 (SD_CK high, SD_DI=0, SD_nCS=0)
      begin
         int rdone;
         rdone    = 0;
         tx_data  = 8'hC3;
         fast     = 1'b1;
         start    = 1'b1;
         cs_write = 1'b1;
         cs_value = 1'b0;
         for (int t = 1; t <= 15; t++) begin
            tick();
            start    = 1'b0;
            cs_write = 1'b0;
         end
         chk("mid_busy", 32'(busy),  32'd1);
         chk("mid_ck",   32'(SD_CK), 32'd1);
         reset = 1'b1;
         tick();
         chk("ar_ck",   32'(SD_CK),   32'd0);
         chk("ar_di",   32'(SD_DI),   32'd1);
         chk("ar_ncs",  32'(SD_nCS),  32'd1);
         chk("ar_busy", 32'(busy),    32'd0);
         chk("ar_rx",   32'(rx_data), 32'h00);
         reset = 1'b0;
         for (int t = 1; t <= 40; t++) begin
            tick();
            if (done) rdone++;
         end
         chk("ar_nodone", 32'(rdone), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
